// File: rtl/alu_rr_arbiter_pkg.sv
// Shared constants for the round-robin ALU arbiter: ALU op codes and FSM states.
package alu_rr_arbiter_pkg;

  localparam int unsigned CTRL_W = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bus between the requesters (master) and the shared-ALU arbiter (slave).
interface alu_rr_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 2
);
  import alu_rr_arbiter_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*XLEN-1:0]   req_op1;
  logic [NREQ*XLEN-1:0]   req_op2;
  logic [NREQ*CTRL_W-1:0] req_ctrl;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [XLEN-1:0]        rsp_res;
  logic                   rsp_zero;
  logic                   busy;

  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_zero, busy
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_zero, busy
  );

endinterface

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational integer ALU; shift amounts at or beyond XLEN saturate (0, or sign fill for SRA).
module alu_rr_arbiter_alu
  import alu_rr_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   op1,
  input  logic [XLEN-1:0]   op2,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   res_c,
  output logic              zero_c
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           shift_big;

  assign shamt     = op2[SHW-1:0];
  assign shift_big = (op2 >= XLEN'(XLEN));

  always_comb begin
    res_c = '0;
    case (ctrl)
      ALU_ADD:  res_c = op1 + op2;
      ALU_SUB:  res_c = op1 - op2;
      ALU_AND:  res_c = op1 & op2;
      ALU_OR:   res_c = op1 | op2;
      ALU_XOR:  res_c = op1 ^ op2;
      ALU_SLL:  res_c = shift_big ? '0 : (op1 << shamt);
      ALU_SRL:  res_c = shift_big ? '0 : (op1 >> shamt);
      ALU_SRA:  res_c = shift_big ? {XLEN{op1[XLEN-1]}} : XLEN'($signed(op1) >>> shamt);
      ALU_SLT:  res_c = XLEN'($signed(op1) < $signed(op2));
      ALU_SLTU: res_c = XLEN'(op1 < op2);
      default:  res_c = '0;
    endcase
  end

  assign zero_c = (res_c == '0);

endmodule

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping, as one-hot plus index.
module alu_rr_arbiter_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDXW-1:0] idx_c,
  output logic            any_c
);

  always_comb begin
    int unsigned j;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_c && req[j]) begin
        any_c    = 1'b1;
        gnt_c[j] = 1'b1;
        idx_c    = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU among NREQ requesters, one transaction at a time (IDLE -> EXEC -> RESP),
// with round-robin grant order advanced only when a response is accepted.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 2
) (
  input logic            clk,
  input logic            reset,
  alu_rr_arbiter_if.slave bus
);

  localparam int unsigned IDXW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   gidx_q, gidx_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              zero_q, zero_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   req_ready_c;

  logic [NREQ-1:0]   pick_gnt;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_any;
  logic [XLEN-1:0]   alu_res;
  logic              alu_zero;

  alu_rr_arbiter_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  alu_rr_arbiter_alu #(.XLEN(XLEN)) u_alu (
    .op1    (op1_q),
    .op2    (op2_q),
    .ctrl   (ctrl_q),
    .res_c  (alu_res),
    .zero_c (alu_zero)
  );

  // Next-state and transaction bookkeeping
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    ctrl_d      = ctrl_q;
    res_d       = res_q;
    zero_d      = zero_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    req_ready_c = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready_c = pick_gnt;
        if (pick_any) begin
          op1_d   = bus.req_op1[pick_idx*XLEN +: XLEN];
          op2_d   = bus.req_op2[pick_idx*XLEN +: XLEN];
          ctrl_d  = bus.req_ctrl[pick_idx*CTRL_W +: CTRL_W];
          gidx_d  = pick_idx;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d       = alu_res;
        zero_d      = alu_zero;
        rsp_valid_d = NREQ'(1) << gidx_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Pointer moves past the served requester only once its result is taken
        if (bus.rsp_ready[gidx_q]) begin
          rsp_valid_d = '0;
          busy_d      = 1'b0;
          ptr_d       = (gidx_q == IDXW'(NREQ-1)) ? '0 : gidx_q + IDXW'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      ctrl_q      <= ctrl_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = res_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.busy      = busy_q;

endmodule
